// File: rtl/bitmap_pkg.sv
// Shared constants and types for the bitmap RAM arbiter.
package bitmap_pkg;
    localparam int ADDR_W         = 14;
    localparam int DATA_W         = 8;
    localparam int PAGE_SIZE      = 8000;
    localparam int BYTES_PER_LINE = 40;

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_HOST} owner_t;
    typedef enum logic {RUN, PEND} swap_state_t;
endpackage

// File: rtl/bitmap_arbiter_if.sv
// Host drawing port: valid/ready request channel plus read-return and error pulses.
interface bitmap_arbiter_if #(
    parameter int ADDR_W = bitmap_pkg::ADDR_W,
    parameter int DATA_W = bitmap_pkg::DATA_W
) ();
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    modport master (output valid, we, addr, wdata, input ready, rdata, rvalid, err);
    modport slave  (input valid, we, addr, wdata, output ready, rdata, rvalid, err);
endinterface

// File: rtl/bitmap_arbiter_page_swap.sv
// Display/draw page exchange, deferred to frame_start so scanout never tears.
module page_swap (
    input  logic clk,
    input  logic rst_n,
    input  logic swap_req_i,
    input  logic frame_start_i,
    output logic swap_done_o,
    output logic display_page_o
);
    import bitmap_pkg::*;

    swap_state_t state_q, state_d;
    logic        page_q, page_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            page_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        done_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                // A request coinciding with the frame boundary is served immediately.
                if (swap_req_i && frame_start_i) begin
                    page_d = ~page_q;
                    done_d = 1'b1;
                end else if (swap_req_i) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (frame_start_i) begin
                    page_d  = ~page_q;
                    done_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign swap_done_o    = done_q;
    assign display_page_o = page_q;
endmodule

// File: rtl/bitmap_arbiter.sv
// Shares the bitmap RAM between scanout fetches (priority) and the host port,
// mapping page-relative offsets onto the display or draw page.
module bitmap_arbiter #(
    parameter int ADDR_W    = bitmap_pkg::ADDR_W,
    parameter int DATA_W    = bitmap_pkg::DATA_W,
    parameter int PAGE_SIZE = bitmap_pkg::PAGE_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [DATA_W-1:0] vid_data_o,
    output logic              vid_valid_o,
    bitmap_arbiter_if.slave   host,
    input  logic              swap_req_i,
    input  logic              frame_start_i,
    output logic              swap_done_o,
    output logic              display_page_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);
    import bitmap_pkg::*;

    localparam logic [ADDR_W-1:0] PAGE_BASE = ADDR_W'(PAGE_SIZE);

    logic              vid_gnt, host_rdy, host_gnt, host_oob;
    logic [ADDR_W-1:0] vid_phys, host_phys;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    owner_t            own_d;
    owner_t            own_q [2];
    logic              err_q;
    logic [DATA_W-1:0] vid_data_q, host_rdata_q;

    page_swap u_page_swap (
        .clk           (clk),
        .rst_n         (rst_n),
        .swap_req_i    (swap_req_i),
        .frame_start_i (frame_start_i),
        .swap_done_o   (swap_done_o),
        .display_page_o(display_page_o)
    );

    // Grants are gated by reset so every output reads 0 while rst_n is low.
    always_comb begin
        vid_gnt   = rst_n & vid_req_i;
        host_rdy  = rst_n & ~vid_req_i;
        host_gnt  = host_rdy & host.valid;
        host_oob  = host.addr >= PAGE_BASE;
        vid_phys  = vid_addr_i + (display_page_o ? PAGE_BASE : '0);
        host_phys = host.addr + (display_page_o ? '0 : PAGE_BASE);

        ram_addr_d = ram_addr_q;
        own_d      = OWN_NONE;
        if (vid_gnt) begin
            ram_addr_d = vid_phys;
            own_d      = OWN_VID;
        end else if (host_gnt) begin
            ram_addr_d = host_phys;
            if (!host.we) own_d = OWN_HOST;
        end
    end

    assign ram_addr_o = ram_addr_d;
    assign ram_we_o   = host_gnt & host.we & ~host_oob;
    assign ram_din_o  = (host_gnt & host.we) ? host.wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q   <= '0;
            own_q[0]     <= OWN_NONE;
            own_q[1]     <= OWN_NONE;
            err_q        <= 1'b0;
            vid_data_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            own_q[0]   <= own_d;
            own_q[1]   <= own_q[0];
            err_q      <= host_gnt & host_oob;
            if (own_q[0] == OWN_VID) vid_data_q <= ram_dout_i;
            // err_q is still aligned with the stage-0 tag, so it flags an out-of-range read.
            if (own_q[0] == OWN_HOST) host_rdata_q <= err_q ? '0 : ram_dout_i;
        end
    end

    assign vid_data_o  = vid_data_q;
    assign vid_valid_o = own_q[1] == OWN_VID;
    assign host.ready  = host_rdy;
    assign host.rdata  = host_rdata_q;
    assign host.rvalid = own_q[1] == OWN_HOST;
    assign host.err    = err_q;
endmodule

// File: doc/bitmap_arbiter.md
# bitmap_arbiter

Shares the single-port, synchronous-read bitmap RAM between the video scanout fetch path and a host drawing port. Also manages double-buffered display pages. Video fetches have absolute priority. Host reads and writes fill every cycle the scanout does not use. A page-swap request is deferred to the next frame boundary so the displayed image never tears. The block sits between the scanout counter logic and the bitmap RAM instance.

## Interface
Parameters:
- ADDR_W, 14, RAM address width
- DATA_W, 8, RAM data width (one byte = 8 pixels)
- PAGE_SIZE, 8000, bytes per page (40 bytes × 200 lines); page 1 base = PAGE_SIZE

Ports:
- clk  in  1  pixel-domain clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vid_req  in  1  scanout fetch strobe, one cycle
- vid_addr  in  ADDR_W  page-relative byte offset
- vid_data  out  DATA_W  fetched byte
- vid_valid  out  1  vid_data valid, one-cycle pulse
- host_valid  in  1  host request present
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  page-relative byte offset
- host_wdata  in  DATA_W  write data
- host_rdata  out  DATA_W  read data
- host_rvalid  out  1  host_rdata valid, one-cycle pulse
- host_err  out  1  one-cycle pulse: accepted request had host_addr ≥ PAGE_SIZE
- swap_req  in  1  request display/draw page exchange, one cycle
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- swap_done  out  1  one-cycle pulse when the swap takes effect
- display_page  out  1  page currently scanned out
- ram_addr  out  ADDR_W  to RAM
- ram_we  out  1  to RAM
- ram_din  out  DATA_W  to RAM
- ram_dout  in  DATA_W  from RAM, valid the cycle after the address is sampled

## Operation
- Grant, combinational each cycle:
  - vid_req=1 → video owns the RAM; host_ready=0.
  - Otherwise host_ready=1 and the host owns the RAM if host_valid=1.
- Physical address:
  - Video: vid_addr + (display_page ? PAGE_SIZE : 0).
  - Host: host_addr + (display_page ? 0 : PAGE_SIZE). The host always targets the draw page (~display_page).
  - Sum is ADDR_W bits; no overflow for legal offsets.
- Idle cycle (no grant): ram_we=0, ram_addr holds its last value.
- Host write: ram_we=1 for the accept cycle, ram_din=host_wdata.
- Out-of-range host request (host_addr ≥ PAGE_SIZE):
  - Still accepted.
  - Writes are suppressed: ram_we=0.
  - Reads return host_rdata=0 with host_rvalid.
  - host_err pulses one cycle after accept.
- Read owner pipeline: a two-stage shift of {NONE, VID, HOST} tags steers the registered ram_dout to vid_data or host_rdata.
- Page-swap FSM states: RUN, PEND.
  - RUN + swap_req → PEND.
  - PEND + frame_start → toggle display_page, pulse swap_done, return to RUN.
  - RUN + swap_req + frame_start in the same cycle → swap at that edge, stay in RUN.
  - swap_req while in PEND → ignored; only one toggle occurs.
- display_page changes only on a frame_start edge. Reads already in flight keep the page they were issued with.

## Timing
- Reset values: all outputs 0, display_page=0, FSM=RUN, owner pipeline=NONE.
- Reset asserted mid-read: the pending rvalid/vid_valid is discarded, not emitted.
- Video read: vid_req in cycle N → RAM samples at end of N → ram_dout in N+1 → vid_data/vid_valid registered, high in N+2. Fixed latency 2.
- Host read: accepted in N → host_rvalid in N+2. Host write: committed at end of N.
- Back-to-back accepts allowed every cycle. Throughput: 1 access/cycle total.
- host_ready depends combinationally on vid_req. The host must hold its request stable until accepted.
- Video fetches at most every 8th cycle in the 320-pixel mode. Host worst-case wait is therefore 1 cycle; no starvation counter is required.

## Structure
- Shared package bitmap_pkg holds:
  - ADDR_W, DATA_W, PAGE_SIZE, BYTES_PER_LINE=40
  - owner_t enum {OWN_NONE, OWN_VID, OWN_HOST}
- Sub-module page_swap: RUN/PEND FSM, display_page register, swap_done pulse.
- Top level contains the grant logic, address mapping, and the owner pipeline.
- Bench RAM model: behavioural 16384×8 array, synchronous read, write-first.

## Test plan
- Reset → all outputs 0, display_page=0. Host writes 0xA5 at offset 10 → RAM[8010]=0xA5. Host read of offset 10 → host_rdata=0xA5 with host_rvalid 2 cycles after accept.
- vid_req and host_valid in the same cycle, vid_addr=0x20 → host_ready=0. Host accepted next cycle. vid_valid lands 2 cycles after vid_req with RAM[0x20].
- swap_req in cycle 5, frame_start in cycle 40 → display_page stays 0 through cycle 40, becomes 1 after that edge, swap_done pulses once. Host write at offset 0 then hits RAM[0].
- swap_req and frame_start in the same cycle, plus a second swap_req while PEND → exactly one toggle per frame_start.
- Host write at offset 8000 → RAM unchanged, host_err pulse. Read at offset 9000 → host_rdata=0, host_rvalid=1, host_err=1.
- rst_n dropped the cycle after a host read is accepted → no host_rvalid. Outputs 0 while rst_n=0. Normal operation resumes after release.
